// File: rtl/count_target_sequencer.sv
// rtl/count_target_sequencer.sv - target FIFO feeding a loadable counter.
// Pops one target per run, enables the counter until count_in matches, then dwells.
module count_target_sequencer #(
  parameter int W         = 4,
  parameter int DEPTH     = 4,
  parameter int DWELL_CYC = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_en_i,
  input  logic [W-1:0]             wr_data_i,
  input  logic                     abort_i,
  input  logic [W-1:0]             count_in_i,
  output logic [W-1:0]             load_o,
  output logic                     opnd_o,
  output logic                     reached_o,
  output logic                     busy_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     ovf_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(DWELL_CYC + 1);

  typedef enum logic [1:0] {IDLE, RUN, DWELL} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q, level_d;
  logic [W-1:0]    load_q;
  logic [CW-1:0]   dwell_q, dwell_d;
  logic            reached_q, reached_d;
  logic            ovf_q;
  logic            full, empty, pop, push_ok;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign pop     = (state_q == IDLE) && !empty;
  // A pop frees a slot at the same edge, so a push into a full FIFO still lands.
  assign push_ok = wr_en_i && (!full || pop);
  assign level_d = level_q + LW'(push_ok) - LW'(pop);

  always_comb begin
    state_d   = state_q;
    dwell_d   = dwell_q;
    reached_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) state_d = RUN;
      end
      RUN: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (count_in_i == load_q) begin
          state_d   = DWELL;
          reached_d = 1'b1;
          dwell_d   = CW'(DWELL_CYC - 1);
        end
      end
      DWELL: begin
        if (abort_i || dwell_q == '0) state_d = IDLE;
        else                          dwell_d = dwell_q - CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      load_q    <= '0;
      dwell_q   <= '0;
      reached_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      dwell_q   <= dwell_d;
      reached_q <= reached_d;
      ovf_q     <= wr_en_i && full && !pop;
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        load_q   <= mem_q[rd_ptr_q];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign load_o    = load_q;
  assign opnd_o    = (state_q == RUN);
  assign reached_o = reached_q;
  assign busy_o    = (state_q != IDLE);
  assign full_o    = full;
  assign empty_o   = empty;
  assign ovf_o     = ovf_q;
  assign level_o   = level_q;

endmodule

// File: doc/count_target_sequencer.md
Name: count_target_sequencer

Overview:
- Upstream feeder for the loadable up/down counter.
- Buffers a queue of 4-bit target values and presents one at a time on `load`. It holds `opnd` high while the counter runs, and watches the counter's `count` fed back on `count_in`.
- When the counter reaches the target, it drops `opnd`, flags `reached`, dwells, then issues the next queued target.

Parameters:
- W, 4, width of target/count values
- DEPTH, 4, target FIFO entries; power of 2, >= 2
- DWELL_CYC, 2, cycles `opnd` stays low after a match before next fetch; >= 1

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- wr_en  input  1  push wr_data into target FIFO
- wr_data  input  W  target value to queue
- abort  input  1  abandon current target, return to IDLE
- count_in  input  W  counter's current count (feedback)
- load  output  W  current target, drives counter load
- opnd  output  1  counter enable, high only in RUN
- reached  output  1  one-cycle pulse, target matched
- busy  output  1  high when state != IDLE
- full  output  1  FIFO holds DEPTH entries
- empty  output  1  FIFO holds 0 entries
- ovf  output  1  one-cycle pulse, push dropped while full
- level  output  clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst=1 at a clk edge) clears everything:
  - state=IDLE; FIFO pointers and level=0; load=0
  - opnd=0, reached=0, ovf=0, busy=0
  - empty=1, full=0
  - dwell counter=0
- Reset mid-RUN discards the queue and target; opnd is low the next cycle.
- All outputs are registered or decoded from registered state only; no combinational path from count_in or wr_en to any output.
- FIFO write:
  - wr_en && !full: entry written, level+1 at the edge.
  - wr_en && full && no pop same cycle: data dropped, ovf=1 next cycle, FIFO unchanged.
  - wr_en && full && pop same cycle: write accepted, level unchanged, no ovf.
  - No write-to-read bypass: a push into an empty FIFO becomes poppable the following cycle.
- Pointers wrap modulo DEPTH. `level` is the authoritative occupancy; full = (level==DEPTH), empty = (level==0).
- State machine (IDLE, RUN, DWELL):
  - IDLE:
    - opnd=0.
    - If !empty: pop head into load at the edge, next state RUN.
    - Else stay in IDLE.
  - RUN:
    - opnd=1.
    - If abort: next IDLE; load holds; no reached.
    - Else if count_in==load (exact W-bit equality): next DWELL, reached=1 for exactly the first DWELL cycle, dwell counter loaded with DWELL_CYC-1.
    - Else stay in RUN.
    - Abort has priority over a same-cycle match.
  - DWELL:
    - opnd=0.
    - Counter decrements each cycle; at 0, next IDLE.
    - abort in DWELL forces IDLE next cycle.
- Latency:
  - Push into empty FIFO at edge t → empty=0 after t → pop and load update at t+1 → opnd=1 from t+1 to t+2 onward. First opnd high cycle is 2 cycles after the push cycle.
  - Match sampled at edge m → opnd=0 and reached=1 in cycle m..m+1. Next possible RUN is DWELL_CYC+1 cycles after m.
- Target already equal to count_in on entering RUN: opnd is high exactly one cycle, then DWELL (one-cycle enable is intentional).
- load changes only on a pop in IDLE; it is stable throughout RUN and DWELL.
- busy = (state != IDLE).
- abort in IDLE has no effect and does not flush the FIFO.

Test Plan:
- Reset, then push 4'd5 at cycle 0, with count_in tracking a 0→5 up-count:
  - load=5 and opnd=1 from cycle 2.
  - reached=1 one cycle after count_in=5.
  - opnd=0 for 2 cycles, then IDLE, empty=1.
- Push 5 values back-to-back with DEPTH=4 and the FSM held in RUN on a long target:
  - full=1 after the 4th push.
  - 5th push gives ovf=1 for one cycle; level stays 4.
  - Queued order is preserved on pops.
- With full=1 and the FSM in IDLE, push in the same cycle as the pop: no ovf, level stays 4, new value is last out.
- In RUN with target 9 and count_in=3, assert abort for one cycle:
  - opnd=0 next cycle, reached never pulses, busy=0.
  - Next queued target is fetched the following cycle.
- Queue targets 7 and 7 with count_in held at 7:
  - Each target gives opnd=1 for exactly one cycle, then a reached pulse.
  - The two RUN cycles are separated by DWELL_CYC+1 cycles.
- Assert rst mid-RUN with level=2: next cycle opnd=0, load=0, level=0, empty=1, state IDLE.
